// File: rtl/sevseg_pkg.sv
// Shared types and the seven-segment font for the multiplexed display scanner.
package sevseg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} glyph for one hex nibble
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevseg_slot_timer.sv
// Slot/digit timing for the scanner: per-slot cycle counter, digit index,
// anti-ghosting blank window and frame-start strobe.
module sevseg_slot_timer #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1,
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_blank_win_c,
    output logic             o_frame_start_c
);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;

    // Counters park at zero while disabled so scanning restarts at digit 0
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_W'(SLOT_CYCLES - 1)) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign o_blank_win_c = 1'b0;
        end else begin : g_blank
            assign o_blank_win_c = (32'(r_cnt) < BLANK_CYCLES);
        end
    endgenerate

    assign o_idx           = r_idx;
    assign o_frame_start_c = i_en && (r_cnt == '0) && (r_idx == '0);

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with frame-coherent snapshot.
// Optional leading-zero blanking when SEVSEG_LZ_SUPPRESS_EN is defined.
module sevseg_scan_ctrl
    import sevseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_n,
    output logic                    frame_tick
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [IDX_W-1:0]        w_idx;
    logic                    w_blank_win;
    logic                    w_frame_start;

    logic [4*NUM_DIGITS-1:0] r_data;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blank;

    logic [4*NUM_DIGITS-1:0] w_snap_data;
    logic [NUM_DIGITS-1:0]   w_snap_dp;
    logic [NUM_DIGITS-1:0]   w_snap_blank;
    logic [NUM_DIGITS-1:0]   w_sup;

    logic [3:0]              w_nib;
    logic                    w_dp;
    logic                    w_blk;
    logic [NUM_DIGITS-1:0]   w_sel_n;

    sevseg_slot_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .i_en            (en),
        .o_idx           (w_idx),
        .o_blank_win_c   (w_blank_win),
        .o_frame_start_c (w_frame_start)
    );

    // In the capture cycle the live inputs are the snapshot, so digit 0 of a
    // frame is coherent even when there is no blank window.
    assign w_snap_data  = w_frame_start ? data     : r_data;
    assign w_snap_dp    = w_frame_start ? dp_in    : r_dp;
    assign w_snap_blank = w_frame_start ? blank_in : r_blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_dp    <= '0;
            r_blank <= '0;
        end else if (w_frame_start) begin
            r_data  <= data;
            r_dp    <= dp_in;
            r_blank <= blank_in;
        end
    end

`ifdef SEVSEG_LZ_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] r_lz;
    logic [NUM_DIGITS-1:0] w_lz_next;
    logic                  w_lead;

    // Walk down from the MSD; the leading run ends at the first shown digit
    always_comb begin
        w_lz_next = '0;
        w_lead    = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_lz_next[i] = w_lead && (w_snap_data[4*i +: 4] == 4'h0) && !w_snap_dp[i];
            w_lead       = w_lead && (w_lz_next[i] || w_snap_blank[i]);
        end
    end

    // Digit 0 is never suppressed, so the mask can lag the capture by a cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lz <= '0;
        end else if (w_frame_start) begin
            r_lz <= w_lz_next;
        end
    end

    assign w_sup = r_lz;
`else
    assign w_sup = '0;
`endif

    always_comb begin
        w_nib   = 4'h0;
        w_dp    = 1'b0;
        w_blk   = 1'b0;
        w_sel_n = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_nib      = w_snap_data[4*i +: 4];
                w_dp       = w_snap_dp[i];
                w_blk      = w_snap_blank[i] || w_sup[i];
                w_sel_n[i] = 1'b0;
            end
        end
    end

    // Blanked digits keep their anode driven so every slot has equal duty
    always_ff @(posedge clk) begin
        if (rst) begin
            segments   <= SEG_OFF;
            digit_n    <= '1;
            frame_tick <= 1'b0;
        end else if (!en) begin
            segments   <= SEG_OFF;
            digit_n    <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_frame_start;
            if (w_blank_win) begin
                segments <= SEG_OFF;
                digit_n  <= '1;
            end else begin
                segments <= w_blk ? SEG_OFF : {~w_dp, hex_to_seg(w_nib)};
                digit_n  <= w_sel_n;
            end
        end
    end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Scoreboarded bench for sevseg_scan_ctrl (4 digits, 4-cycle slots, 1 blank cycle).
module tb_sevseg_scan_ctrl;

    localparam int ND = 4;
    localparam int SC = 4;
    localparam int BC = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] data = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [7:0]  segments;
    logic [3:0]  digit_n;
    logic        frame_tick;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] dn;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0] font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    sevseg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SLOT_CYCLES  (SC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data       (data),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .segments   (segments),
        .digit_n    (digit_n),
        .frame_tick (frame_tick)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, want);
        end
    endtask

    // Reference model: a single frame-position counter split into digit/phase
    int         m_pos = 0;
    logic [15:0] m_data = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic [3:0]  m_blank = 4'h0;
    logic [3:0]  m_lz = 4'h0;

    always @(posedge clk) begin : model
        exp_t       e;
        int         dig;
        int         ph;
        logic [1:0] d2;
        logic [3:0] nib;
        e = '{8'hFF, 4'hF, 1'b0};
        if (rst) begin
            m_pos = 0; m_data = 16'h0; m_dp = 4'h0; m_blank = 4'h0; m_lz = 4'h0;
        end else if (!en) begin
            m_pos = 0;
        end else begin
            if (m_pos == 0) begin
                m_data = data; m_dp = dp_in; m_blank = blank_in; m_lz = 4'h0;
`ifdef SEVSEG_LZ_SUPPRESS_EN
                for (int d = ND - 1; d >= 1; d--) begin
                    nib = 4'(m_data >> (4 * d));
                    if (m_blank[2'(d)]) continue;
                    if (nib != 4'h0 || m_dp[2'(d)]) break;
                    m_lz[2'(d)] = 1'b1;
                end
`endif
                e.tick = 1'b1;
            end
            dig = m_pos / SC;
            ph  = m_pos % SC;
            d2  = 2'(dig);
            if (ph >= BC) begin
                e.dn = ~(4'b0001 << d2);
                nib  = 4'(m_data >> (4 * dig));
                if (!(m_blank[d2] || m_lz[d2]))
                    e.seg = {~m_dp[d2], font_tab[nib]};
            end
            m_pos = (m_pos + 1) % (ND * SC);
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("segments",   32'(segments),   32'(e.seg));
            check_eq("digit_n",    32'(digit_n),    32'(e.dn));
            check_eq("frame_tick", 32'(frame_tick), 32'(e.tick));
        end
    end

    // Returns at the negedge where frame_tick is seen, k = negedges waited
    task automatic wait_tick(input string tag, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_tick && k < 64);
        check_eq(tag, 32'(frame_tick), 32'd1);
    endtask

    initial begin
        int k;
        rst = 1'b1; en = 1'b1; data = 16'h1234;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        wait_tick("tick_first", k);
        wait_tick("tick_second", k);
        check_eq("tick_period", 32'(k), 32'(ND * SC));
        @(negedge clk);
        check_eq("d0_seg_1234", 32'(segments), 32'h99);
        check_eq("d0_an_1234",  32'(digit_n),  32'hE);

        wait_tick("tick_pre_abcd", k);
        data = 16'hABCD;
        wait_tick("tick_abcd", k);
        @(negedge clk);
        check_eq("d0_seg_abcd", 32'(segments), 32'hA1);

        dp_in = 4'b0010; blank_in = 4'b1000; data = 16'h0008;
        wait_tick("tick_dp_a", k);
        wait_tick("tick_dp_b", k);
        @(negedge clk);
        check_eq("d0_seg_dp", 32'(segments), 32'h80);
        repeat (4) @(negedge clk);
        check_eq("d1_seg_dp", 32'(segments), 32'h40);
        check_eq("d1_an_dp",  32'(digit_n),  32'hD);

        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (digit_n != 4'hB && k < 40);
        check_eq("find_d2", 32'(digit_n), 32'hB);
        en = 1'b0;
        @(negedge clk);
        check_eq("en_off_an",  32'(digit_n),  32'hF);
        check_eq("en_off_seg", 32'(segments), 32'hFF);
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_tick("tick_restart", k);
        check_eq("restart_lat", 32'(k), 32'd1);
        @(negedge clk);
        check_eq("restart_d0", 32'(digit_n), 32'hE);

        dp_in = 4'h0; blank_in = 4'h0; data = 16'h0050;
        repeat (40) @(negedge clk);
        data = 16'h0000;
        repeat (40) @(negedge clk);

        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_an",   32'(digit_n),    32'hF);
        check_eq("midrst_tick", 32'(frame_tick), 32'd0);
        rst = 1'b0;

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) data = 16'($urandom);
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_in = 4'($urandom);
            if ($urandom_range(0, 49) == 0) en = ~en;
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0; en = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
